// File: rtl/ext_platform_pkg.sv
// Purpose : shared parameter defaults and width helpers for the extensible-platform
//           simulation wrapper.
// Ports   : none (package).
package ext_platform_pkg;

   localparam int unsigned RESET_DELAY_DEF = 16;
   localparam int unsigned LOCK_CYCLES_DEF = 8;
   localparam int unsigned CLK_DIV_DEF     = 2;
   localparam int unsigned CNT_W_DEF       = 32;

   // Width of a counter that must hold values 0..max_val, never narrower than 1 bit.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val <= 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of the divider phase counter: clog2(CLK_DIV/2), minimum 1 bit.
   function automatic int unsigned div_cnt_w(input int unsigned clk_div);
      int unsigned half;
      half = clk_div / 2;
      return (half <= 1) ? 1 : $clog2(half);
   endfunction

endpackage

// File: rtl/ext_platform_part_sim_wrapper_if.sv
// Purpose : bundles the generated reset, lock, divided clock and edge counters.
// Ports   : master drives all signals (the wrapper), slave observes them.
//           pl_resetn1, clk_wiz_locked, clk_out1 : 1 bit
//           pl_clk0_cnt, clk_out1_cnt           : CNT_W bits
interface ext_platform_part_sim_wrapper_if #(
   parameter int unsigned CNT_W = 32
);
   logic             pl_resetn1;
   logic             clk_wiz_locked;
   logic             clk_out1;
   logic [CNT_W-1:0] pl_clk0_cnt;
   logic [CNT_W-1:0] clk_out1_cnt;

   modport master (
      output pl_resetn1,
      output clk_wiz_locked,
      output clk_out1,
      output pl_clk0_cnt,
      output clk_out1_cnt
   );

   modport slave (
      input pl_resetn1,
      input clk_wiz_locked,
      input clk_out1,
      input pl_clk0_cnt,
      input clk_out1_cnt
   );
endinterface

// File: rtl/ext_platform_rst_stretch.sv
// Purpose : stretched PL reset. Asserts asynchronously with i_rst_n, releases
//           synchronously on the RESET_DELAY-th edge after i_rst_n is sampled high.
// Ports   : i_clk    - clock
//           i_rst_n  - raw async active-low reset
//           o_resetn - stretched active-low reset (registered)
module ext_platform_rst_stretch
   import ext_platform_pkg::*;
#(
   parameter int unsigned RESET_DELAY = RESET_DELAY_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_resetn
);

   // First synchronizer stage is r_sync0; the second stage (r_resetn) only
   // loads once the stretch counter has seen enough synchronized-high edges.
   localparam int unsigned TGT = RESET_DELAY - 2;
   localparam int unsigned CW  = cnt_w(TGT);

   logic          r_sync0;
   logic          r_resetn;
   logic [CW-1:0] r_cnt;

   // Synchronizer plus saturating stretch counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync0  <= 1'b0;
         r_resetn <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync0 <= 1'b1;
         if (r_sync0 && (r_cnt != CW'(TGT))) begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_resetn <= r_sync0 && (r_cnt == CW'(TGT));
      end
   end

   assign o_resetn = r_resetn;

endmodule

// File: rtl/ext_platform_part_sim_wrapper.sv
// Purpose : simulation stand-in for the extensible-platform top: stretched PL
//           reset, lock indicator, divided clock and free-running edge counters.
// Ports   : pl_clk0    - sole clock
//           pl0_resetn - raw async active-low platform reset
//           bus        - master modport carrying pl_resetn1, clk_wiz_locked,
//                        clk_out1, pl_clk0_cnt, clk_out1_cnt (all registered)
module ext_platform_part_sim_wrapper
   import ext_platform_pkg::*;
#(
   parameter int unsigned RESET_DELAY = RESET_DELAY_DEF,
   parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
   parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input logic                             pl_clk0,
   input logic                             pl0_resetn,
   ext_platform_part_sim_wrapper_if.master bus
);

   localparam int unsigned HALF = CLK_DIV / 2;
   localparam int unsigned DW   = div_cnt_w(CLK_DIV);
   localparam int unsigned LTGT = LOCK_CYCLES - 1;
   localparam int unsigned LW   = cnt_w(LTGT);

   logic             w_resetn1;
   logic [LW-1:0]    r_lock_cnt;
   logic             r_locked;
   logic [DW-1:0]    r_div;
   logic             r_clk_out;
   logic [CNT_W-1:0] r_pl_cnt;
   logic [CNT_W-1:0] r_co_cnt;

   ext_platform_rst_stretch #(
      .RESET_DELAY (RESET_DELAY)
   ) u_rst_stretch (
      .i_clk    (pl_clk0),
      .i_rst_n  (pl0_resetn),
      .o_resetn (w_resetn1)
   );

   // Lock: counts edges with the stretched reset released, saturates, then holds.
   always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
      if (!pl0_resetn) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else begin
         if (w_resetn1 && (r_lock_cnt != LW'(LTGT))) begin
            r_lock_cnt <= r_lock_cnt + LW'(1);
         end
         r_locked <= w_resetn1 && (r_lock_cnt == LW'(LTGT));
      end
   end

   // Divider: toggles every HALF edges once locked; counts each 0->1 transition.
   always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
      if (!pl0_resetn) begin
         r_div     <= '0;
         r_clk_out <= 1'b0;
         r_co_cnt  <= '0;
      end else if (!r_locked) begin
         r_div     <= '0;
         r_clk_out <= 1'b0;
      end else if (r_div == DW'(HALF - 1)) begin
         r_div     <= '0;
         r_clk_out <= ~r_clk_out;
         if (!r_clk_out) begin
            r_co_cnt <= r_co_cnt + CNT_W'(1);
         end
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   // Free-running source-clock edge counter.
   always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
      if (!pl0_resetn) begin
         r_pl_cnt <= '0;
      end else begin
         r_pl_cnt <= r_pl_cnt + CNT_W'(1);
      end
   end

   assign bus.pl_resetn1     = w_resetn1;
   assign bus.clk_wiz_locked = r_locked;
   assign bus.clk_out1       = r_clk_out;
   assign bus.pl_clk0_cnt    = r_pl_cnt;
   assign bus.clk_out1_cnt   = r_co_cnt;

endmodule

// File: tb/tb_ext_platform_part_sim_wrapper.sv
// Purpose : self-checking bench for ext_platform_part_sim_wrapper. Three instances
//           (defaults, CLK_DIV=6, CNT_W=4) share clock and reset and are compared
//           every edge against a model computed from the edge count since release.
module tb_ext_platform_part_sim_wrapper;

   localparam int unsigned RD = 16;
   localparam int unsigned LC = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned k     = 0;
   int          cmp_cnt = 0;
   int          err_cnt = 0;

   int unsigned div_tab [3] = '{2, 6, 2};
   int unsigned w_tab   [3] = '{32, 32, 4};

   always #5 clk = ~clk;

   ext_platform_part_sim_wrapper_if #(.CNT_W(32)) bus0 ();
   ext_platform_part_sim_wrapper_if #(.CNT_W(32)) bus1 ();
   ext_platform_part_sim_wrapper_if #(.CNT_W(4))  bus2 ();

   ext_platform_part_sim_wrapper #(.RESET_DELAY(RD), .LOCK_CYCLES(LC), .CLK_DIV(2), .CNT_W(32)) u_dut0 (
      .pl_clk0 (clk), .pl0_resetn (rst_n), .bus (bus0));
   ext_platform_part_sim_wrapper #(.RESET_DELAY(RD), .LOCK_CYCLES(LC), .CLK_DIV(6), .CNT_W(32)) u_dut1 (
      .pl_clk0 (clk), .pl0_resetn (rst_n), .bus (bus1));
   ext_platform_part_sim_wrapper #(.RESET_DELAY(RD), .LOCK_CYCLES(LC), .CLK_DIV(2), .CNT_W(4)) u_dut2 (
      .pl_clk0 (clk), .pl0_resetn (rst_n), .bus (bus2));

   wire [66:0] obs0 = {bus0.pl_resetn1, bus0.clk_wiz_locked, bus0.clk_out1,
                       bus0.pl_clk0_cnt, bus0.clk_out1_cnt};
   wire [66:0] obs1 = {bus1.pl_resetn1, bus1.clk_wiz_locked, bus1.clk_out1,
                       bus1.pl_clk0_cnt, bus1.clk_out1_cnt};
   wire [66:0] obs2 = {bus2.pl_resetn1, bus2.clk_wiz_locked, bus2.clk_out1,
                       28'd0, bus2.pl_clk0_cnt, 28'd0, bus2.clk_out1_cnt};

   function automatic logic [66:0] get_obs(input int i);
      return (i == 0) ? obs0 : (i == 1) ? obs1 : obs2;
   endfunction

   // Expected outputs after kk edges since release: reset high from edge RD, lock
   // from RD+LC, then one toggle every div/2 edges; rises = ceil(toggles/2).
   function automatic logic [66:0] model(input int unsigned kk, input int unsigned div,
                                         input int unsigned w);
      longint unsigned lk_edge, t, mask;
      logic            rn, lk, co;
      logic [31:0]     pc, cc;
      lk_edge = longint'(RD + LC);
      t       = (kk >= lk_edge) ? (longint'(kk) - lk_edge) / longint'(div / 2) : 64'd0;
      mask    = (64'd1 << w) - 64'd1;
      rn      = (kk >= RD);
      lk      = (kk >= lk_edge);
      co      = t[0];
      pc      = 32'(longint'(kk) & mask);
      cc      = 32'(((t + 64'd1) / 64'd2) & mask);
      return {rn, lk, co, pc, cc};
   endfunction

   // One clock edge; the model edge index advances only while reset is released.
   task automatic step();
      @(posedge clk);
      if (rst_n) k++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [66:0] got, exp;
      rst_n = 1'b0;
      k     = 0;
      for (int n = 0; n < 4; n++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            exp = model(k, div_tab[i], w_tab[i]);
            got = get_obs(i);
            cmp_cnt++;
            if (got !== exp) begin
               err_cnt++;
               $display("FAIL reset inst%0d cyc=%0d got=%h exp=%h", i, n, got, exp);
            end
         end
      end
   endtask

   task automatic test_release(input int unsigned edges);
      logic [66:0] got, exp;
      rst_n = 1'b1;
      for (int n = 0; n < int'(edges); n++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            exp = model(k, div_tab[i], w_tab[i]);
            got = get_obs(i);
            cmp_cnt++;
            if (got !== exp) begin
               err_cnt++;
               $display("FAIL release inst%0d edge=%0d got=%h exp=%h", i, k, got, exp);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [66:0] got, exp, m;
      // advance until the default instance is predicted to have clk_out1 high
      for (int n = 0; n < 4; n++) begin
         m = model(k, 2, 32);
         if (m[64]) break;
         step();
      end
      #2 rst_n = 1'b0;
      k = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp = model(0, div_tab[i], w_tab[i]);
         got = get_obs(i);
         cmp_cnt++;
         if (got !== exp) begin
            err_cnt++;
            $display("FAIL mid_reset_async inst%0d got=%h exp=%h", i, got, exp);
         end
      end
      @(negedge clk);
      for (int n = 0; n < int'($urandom_range(1, 3)); n++) step();
      test_release(40);
   endtask

   task automatic test_early_drop();
      logic [66:0] got, exp;
      int unsigned n_edges;
      #1 rst_n = 1'b0;
      k = 0;
      @(negedge clk);
      rst_n   = 1'b1;
      n_edges = $urandom_range(3, RD - 2);
      for (int n = 0; n < int'(n_edges); n++) begin
         step();
         for (int i = 0; i < 3; i++) begin
            exp = model(k, div_tab[i], w_tab[i]);
            got = get_obs(i);
            cmp_cnt++;
            if (got !== exp) begin
               err_cnt++;
               $display("FAIL early_drop inst%0d edge=%0d got=%h exp=%h", i, k, got, exp);
            end
         end
      end
      #2 rst_n = 1'b0;
      k = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp = model(0, div_tab[i], w_tab[i]);
         got = get_obs(i);
         cmp_cnt++;
         if (got !== exp) begin
            err_cnt++;
            $display("FAIL early_drop_clear inst%0d got=%h exp=%h", i, got, exp);
         end
      end
      @(negedge clk);
      test_release(30);
   endtask

   task automatic test_glitch();
      logic [66:0] got, exp;
      for (int n = 0; n < int'($urandom_range(5, 40)); n++) step();
      @(posedge clk);
      if (rst_n) k++;
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      k = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp = model(0, div_tab[i], w_tab[i]);
         got = get_obs(i);
         cmp_cnt++;
         if (got !== exp) begin
            err_cnt++;
            $display("FAIL glitch_clear inst%0d got=%h exp=%h", i, got, exp);
         end
      end
      @(negedge clk);
      test_release(30);
   endtask

   initial begin
      test_reset();
      test_release(60);
      test_mid_reset();
      test_early_drop();
      test_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
